canny_frame_sequencer: RTL and testbench

Frame-level controller for the Canny streaming pipeline inside the VIP flow-control wrapper. Latches the decoded control packet, issues the outgoing control packet, and gates the pipeline's input-FIFO writes and output-FIFO reads against the frame pixel count. Generates `end_of_video_out` on the true last output pixel, so EOV no longer tracks the input side. Sits between the VIP wrapper ports and the pipeline FIFOs; pixel data bypasses it.

---
 rtl/canny_seq_pkg.sv | 41 ++++
 rtl/frame_pixel_counter.sv | 42 ++++
 rtl/canny_frame_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_canny_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_seq_pkg.sv
// Shared types and constants for the Canny frame sequencer and its pixel counters.
package canny_seq_pkg;

  localparam int DIM_W = 16;
  localparam int CNT_W = 32;
  localparam int IL_W  = 4;

  localparam int unsigned DEFAULT_WIDTH_C  = 640;
  localparam int unsigned DEFAULT_HEIGHT_C = 480;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CTRL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_CTRL   = S_CTRL,
    ST_STREAM = S_STREAM,
    ST_DRAIN  = S_DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
    logic [IL_W-1:0]  interlaced;
  } ctrl_pkt_t;

  typedef struct packed {
    seq_state_e       state;
    logic             pend_valid;
    logic [CNT_W-1:0] in_count;
    logic [CNT_W-1:0] out_count;
  } seq_dbg_t;

  function automatic logic [CNT_W-1:0] frame_total(input logic [DIM_W-1:0] w,
                                                   input logic [DIM_W-1:0] h);
    return CNT_W'(w) * CNT_W'(h);
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Per-frame pixel counter with "one before last" and "complete" flags.
module frame_pixel_counter
  import canny_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             set_done,
  input  logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] count,
  output logic             at_last,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  // set_done jumps straight to total so an early end-of-video closes the frame.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (set_done) begin
      count_d = total;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_last = (count_q == (total - CNT_W'(1)));
  assign done    = (count_q >= total);

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame-level controller: latches control packets, issues the outgoing control
// packet and gates pipeline FIFO traffic against the frame pixel count.
module canny_frame_sequencer
  import canny_seq_pkg::*;
#(
  parameter int unsigned DEFAULT_WIDTH  = DEFAULT_WIDTH_C,
  parameter int unsigned DEFAULT_HEIGHT = DEFAULT_HEIGHT_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vip_ctrl_valid,
  input  logic [DIM_W-1:0] width_in,
  input  logic [DIM_W-1:0] height_in,
  input  logic [IL_W-1:0]  interlaced_in,
  input  logic             vip_ctrl_busy,
  output logic             vip_ctrl_send,
  output logic [DIM_W-1:0] width_out,
  output logic [DIM_W-1:0] height_out,
  output logic [IL_W-1:0]  interlaced_out,
  input  logic             stall_in,
  input  logic             end_of_video,
  output logic             read,
  input  logic             pipe_in_full,
  output logic             pipe_wr_en,
  input  logic             stall_out,
  input  logic             pipe_out_empty,
  output logic             pipe_rd_en,
  output logic             write,
  output logic             end_of_video_out,
  output logic             frame_active,
  output logic             eov_mismatch,
  output seq_dbg_t         seq_dbg
);

  seq_state_e       state_q, state_d;
  ctrl_pkt_t        dims_q, dims_d;
  ctrl_pkt_t        pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             send_q, send_d;
  logic             write_q, write_d;
  logic             last_q, last_d;
  logic             mismatch_q, mismatch_d;

  ctrl_pkt_t        in_pkt, sel_pkt;
  logic             sel_vld, start, in_idle, streaming, out_side;
  logic             read_c, wr_c, rd_c, eov_early, frame_done;
  logic [CNT_W-1:0] in_count, out_count;
  logic             in_at_last, in_done, out_at_last, out_done;

  assign in_pkt = '{width: width_in, height: height_in, interlaced: interlaced_in};

  assign in_idle   = (state_q == ST_IDLE);
  assign streaming = (state_q == ST_STREAM);
  assign out_side  = streaming | (state_q == ST_DRAIN);

  // A live packet in IDLE is newer than anything pending, so it takes priority.
  always_comb begin
    sel_pkt = pend_q;
    sel_vld = pend_vld_q;
    if (vip_ctrl_valid) begin
      sel_pkt = in_pkt;
      sel_vld = 1'b1;
    end
  end

  assign start = in_idle & sel_vld & (sel_pkt.width != '0) & (sel_pkt.height != '0);

  // Handshakes: a FIFO word moves on the cycle its enable is high (wr_en needs
  // !full, rd_en needs !empty); an output word is valid while write is high and
  // is consumed on a cycle with write & !stall_out, held unchanged otherwise.
  assign read_c     = streaming & ~stall_out & ~pipe_in_full & ~in_done;
  assign wr_c       = read_c & ~stall_in;
  assign eov_early  = wr_c & end_of_video & ~in_at_last;
  assign rd_c       = out_side & ~pipe_out_empty & ~out_done & (~write_q | ~stall_out);
  assign frame_done = write_q & ~stall_out & last_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CTRL;
      ST_CTRL:   if (!vip_ctrl_busy) state_d = ST_STREAM;
      ST_STREAM: if (in_done) state_d = frame_done ? ST_IDLE : ST_DRAIN;
      ST_DRAIN:  if (frame_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dims_d     = dims_q;
    total_d    = total_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (start) begin
      dims_d  = sel_pkt;
      total_d = frame_total(sel_pkt.width, sel_pkt.height);
    end
    if (in_idle) begin
      pend_vld_d = 1'b0;
    end else if (vip_ctrl_valid) begin
      pend_d     = in_pkt;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    send_d     = (state_q == ST_CTRL) & ~vip_ctrl_busy;
    write_d    = rd_c | (write_q & stall_out);
    last_d     = last_q;
    mismatch_d = mismatch_q | eov_early;
    if (in_idle) begin
      last_d = 1'b0;
    end else if (rd_c) begin
      last_d = out_at_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dims_q     <= '{width: DIM_W'(DEFAULT_WIDTH), height: DIM_W'(DEFAULT_HEIGHT),
                      interlaced: '0};
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      total_q    <= '0;
      send_q     <= 1'b0;
      write_q    <= 1'b0;
      last_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dims_q     <= dims_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      total_q    <= total_d;
      send_q     <= send_d;
      write_q    <= write_d;
      last_q     <= last_d;
      mismatch_q <= mismatch_d;
    end
  end

  frame_pixel_counter u_in_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (in_idle),
    .inc      (wr_c),
    .set_done (eov_early),
    .total    (total_q),
    .count    (in_count),
    .at_last  (in_at_last),
    .done     (in_done)
  );

  frame_pixel_counter u_out_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (in_idle),
    .inc      (rd_c),
    .set_done (1'b0),
    .total    (total_q),
    .count    (out_count),
    .at_last  (out_at_last),
    .done     (out_done)
  );

  assign vip_ctrl_send    = send_q;
  assign width_out        = dims_q.width;
  assign height_out       = dims_q.height;
  assign interlaced_out   = dims_q.interlaced;
  assign read             = read_c;
  assign pipe_wr_en       = wr_c;
  assign pipe_rd_en       = rd_c;
  assign write            = write_q;
  assign end_of_video_out = write_q & last_q;
  assign frame_active     = ~in_idle;
  assign eov_mismatch     = mismatch_q;

  assign seq_dbg = '{state: state_q, pend_valid: pend_vld_q,
                     in_count: in_count, out_count: out_count};

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Bench for canny_frame_sequencer: frame vectors plus hand-written corner sequences.
module tb_canny_frame_sequencer;
  import canny_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             vip_ctrl_valid;
  logic [DIM_W-1:0] width_in, height_in;
  logic [IL_W-1:0]  interlaced_in;
  logic             vip_ctrl_busy, vip_ctrl_send;
  logic [DIM_W-1:0] width_out, height_out;
  logic [IL_W-1:0]  interlaced_out;
  logic             stall_in, end_of_video, read, pipe_in_full, pipe_wr_en;
  logic             stall_out, pipe_out_empty, pipe_rd_en, write;
  logic             end_of_video_out, frame_active, eov_mismatch;
  seq_dbg_t         seq_dbg;

  always #5 clk = ~clk;

  canny_frame_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .vip_ctrl_valid   (vip_ctrl_valid),
    .width_in         (width_in),
    .height_in        (height_in),
    .interlaced_in    (interlaced_in),
    .vip_ctrl_busy    (vip_ctrl_busy),
    .vip_ctrl_send    (vip_ctrl_send),
    .width_out        (width_out),
    .height_out       (height_out),
    .interlaced_out   (interlaced_out),
    .stall_in         (stall_in),
    .end_of_video     (end_of_video),
    .read             (read),
    .pipe_in_full     (pipe_in_full),
    .pipe_wr_en       (pipe_wr_en),
    .stall_out        (stall_out),
    .pipe_out_empty   (pipe_out_empty),
    .pipe_rd_en       (pipe_rd_en),
    .write            (write),
    .end_of_video_out (end_of_video_out),
    .frame_active     (frame_active),
    .eov_mismatch     (eov_mismatch),
    .seq_dbg          (seq_dbg)
  );

  int total_n = 0;
  int bad_n   = 0;

  logic [0:0] exp_q[$];
  int         tot_q[$];

  int fifo_cnt, in_seen, out_seen, cur_total, wr_cnt, send_cnt, send_cyc;
  int first_read_cyc, read_early, stall_hold, rd_in_stall, eov_cnt, busy_left;
  int cyc = 0;
  int frame_n;
  int cfg_eov_at, cfg_stall_at, cfg_stall_len;
  bit cfg_rnd;

  typedef struct {
    int w; int h; int busy; int eov_at; int stall_at; int stall_len; bit rnd;
    int exp_wr; int exp_words; bit exp_mm;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample one cycle's outputs and advance the pipeline/scoreboard model.
  task automatic observe();
    logic [0:0] e;
    cyc++;
    if (busy_left > 0) busy_left--;
    if (vip_ctrl_send) begin
      send_cnt++;
      send_cyc = cyc;
      in_seen  = 0;
      if (tot_q.size() == 0) check("tot_underflow", 1, 0);
      else cur_total = tot_q.pop_front();
    end
    if (read && first_read_cyc < 0) first_read_cyc = cyc;
    if (read && send_cnt == 0) read_early++;
    if (pipe_wr_en) begin
      wr_cnt++;
      if (end_of_video && (in_seen + 1 != cur_total)) fifo_cnt += cur_total - in_seen;
      else fifo_cnt++;
      in_seen++;
    end
    if (pipe_rd_en) begin
      fifo_cnt--;
      if (write && stall_out) rd_in_stall++;
    end
    if (write && stall_out) stall_hold++;
    if (write && !stall_out) begin
      out_seen++;
      if (end_of_video_out) eov_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("eov_word", end_of_video_out, e);
      end
    end
  endtask

  task automatic cycle();
    pipe_out_empty = (fifo_cnt == 0);
    end_of_video   = (cfg_eov_at != 0) && (in_seen + 1 == cfg_eov_at);
    stall_out      = (cfg_stall_at != 0) && write && (out_seen + 1 == cfg_stall_at) &&
                     (stall_hold < cfg_stall_len);
    vip_ctrl_busy  = (busy_left > 0);
    stall_in       = cfg_rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    #2;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_width"}, width_out, 640);
    check({tag, "_height"}, height_out, 480);
    check({tag, "_il"}, interlaced_out, 0);
    check({tag, "_bits"}, {vip_ctrl_send, read, pipe_wr_en, pipe_rd_en, write,
                           end_of_video_out, frame_active, eov_mismatch}, 0);
    check({tag, "_state"}, seq_dbg.state, ST_IDLE);
  endtask

  task automatic clear_model();
    exp_q.delete();
    tot_q.delete();
    fifo_cnt = 0; in_seen = 0; out_seen = 0; cur_total = 0; busy_left = 0;
    cfg_eov_at = 0; cfg_stall_at = 0; cfg_stall_len = 0; cfg_rnd = 0;
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    vip_ctrl_valid = 0; width_in = 0; height_in = 0; interlaced_in = 0;
    vip_ctrl_busy = 0; stall_in = 0; end_of_video = 0; pipe_in_full = 0;
    stall_out = 0; pipe_out_empty = 1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    if (chk) check_reset_vals("reset");
    rst = 1'b0;
  endtask

  task automatic start_frame(input int w, input int h, input int busy);
    wr_cnt = 0; out_seen = 0; send_cnt = 0; first_read_cyc = -1; read_early = 0;
    stall_hold = 0; rd_in_stall = 0; eov_cnt = 0;
    vip_ctrl_valid = 1'b1;
    width_in       = DIM_W'(w);
    height_in      = DIM_W'(h);
    interlaced_in  = IL_W'(w + h);
    for (int i = 0; i < w * h; i++) exp_q.push_back(1'(i == w * h - 1));
    tot_q.push_back(w * h);
    cycle();
    frame_n        = cyc;
    vip_ctrl_valid = 1'b0;
    busy_left      = busy;
    check("dims_w", width_out, w);
    check("dims_h", height_out, h);
    check("dims_il", interlaced_out, (w + h) % 16);
    check("active", frame_active, 1);
  endtask

  task automatic run_vector(input vec_t v);
    do_reset(0);
    cfg_eov_at = v.eov_at; cfg_stall_at = v.stall_at;
    cfg_stall_len = v.stall_len; cfg_rnd = v.rnd;
    start_frame(v.w, v.h, v.busy);
    for (int i = 0; i < 400 && frame_active; i++) cycle();
    check("frame_end", frame_active, 0);
    check("send_cnt", send_cnt, 1);
    check("send_cyc", send_cyc - frame_n, 2 + v.busy);
    check("first_read", first_read_cyc - frame_n, 2 + v.busy);
    check("read_early", read_early, 0);
    check("wr_cnt", wr_cnt, v.exp_wr);
    check("words", out_seen, v.exp_words);
    check("eov_cnt", eov_cnt, 1);
    check("mismatch", eov_mismatch, v.exp_mm);
    check("stall_hold", stall_hold, v.stall_len);
    check("rd_in_stall", rd_in_stall, 0);
    check("sb_left", exp_q.size(), 0);
  endtask

  initial begin
    //          w  h busy eov stall len rnd  wr words mm
    vecs[0] = '{4, 2, 0,   0,  0,   0,  0,   8,  8,   0};
    vecs[1] = '{4, 2, 5,   0,  0,   0,  0,   8,  8,   0};
    vecs[2] = '{4, 2, 0,   0,  3,   4,  0,   8,  8,   0};
    vecs[3] = '{4, 2, 0,   5,  0,   0,  0,   5,  8,   1};
    vecs[4] = '{1, 1, 0,   0,  0,   0,  0,   1,  1,   0};
    vecs[5] = '{3, 3, 2,   0,  1,   2,  1,   9,  9,   0};
    vecs[6] = '{2, 4, 0,   8,  0,   0,  0,   8,  8,   0};
    vecs[7] = '{5, 3, 0,  10,  6,   3,  1,  10, 15,   1};

    do_reset(1);

    // Zero dimensions in IDLE are ignored.
    vip_ctrl_valid = 1; width_in = 0; height_in = 5;
    cycle();
    width_in = 7; height_in = 0;
    cycle();
    vip_ctrl_valid = 0;
    cycle();
    check("zero_active", frame_active, 0);
    check("zero_width", width_out, 640);

    foreach (vecs[i]) run_vector(vecs[i]);

    // Control packet arriving mid-STREAM is held until the frame completes.
    do_reset(0);
    start_frame(4, 2, 0);
    repeat (3) cycle();
    vip_ctrl_valid = 1; width_in = 2; height_in = 2; interlaced_in = 4'd9;
    for (int i = 0; i < 4; i++) exp_q.push_back(1'(i == 3));
    tot_q.push_back(4);
    cycle();
    vip_ctrl_valid = 0;
    check("mid_hold_w", width_out, 4);
    for (int i = 0; i < 400 && !(send_cnt == 2 && !frame_active); i++) cycle();
    check("mid_end", (send_cnt == 2) && !frame_active, 1);
    check("mid_words", out_seen, 12);
    check("mid_wr", wr_cnt, 12);
    check("mid_eov", eov_cnt, 2);
    check("mid_w", width_out, 2);
    check("mid_h", height_out, 2);
    check("mid_il", interlaced_out, 9);
    check("mid_sb", exp_q.size(), 0);

    // Reset pulse mid-STREAM aborts at once.
    do_reset(0);
    start_frame(4, 2, 0);
    repeat (4) cycle();
    check("pre_rst_active", frame_active, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    check("rst_no_eov", eov_cnt, 0);
    repeat (3) cycle();
    check("rst_idle", frame_active, 0);
    check("rst_write", write, 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
